// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a word FIFO at 0xFFFC, a status/clear register at 0xFFFD,
// and an 8N1 serializer that sends each 16-bit word as two frames, low byte first.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [15:0]        DATA_ADDR   = 16'hFFFC;
  localparam logic [15:0]        STATUS_ADDR = 16'hFFFD;
  localparam logic [BAUD_W-1:0]  BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [COUNT_W-1:0] COUNT_FULL  = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [15:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_d;

  logic push_req;
  logic clear_req;
  logic pop;
  logic push_ok;

  // Serializer state
  state_t            state_q;
  state_t            state_d;
  logic [15:0]       word_q;
  logic [15:0]       word_d;
  logic              byte_sel_q;
  logic              byte_sel_d;
  logic [2:0]        bit_idx_q;
  logic [2:0]        bit_idx_d;
  logic [BAUD_W-1:0] baud_cnt_q;
  logic [BAUD_W-1:0] baud_cnt_d;
  logic              bit_end;
  logic [7:0]        cur_byte;
  logic              tx_d;

  // Register decode and FIFO push/pop arbitration
  always_comb begin
    push_req  = mem_write && (mem_addr == DATA_ADDR);
    clear_req = mem_write && (mem_addr == STATUS_ADDR) && mem_wdata[0];
    pop       = (state_q == IDLE) && (count != '0);
    push_ok   = push_req && ((count != COUNT_FULL) || pop);
    count_d   = count;
    if (push_ok && !pop) begin
      count_d = count + COUNT_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_d;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // A push that coincides with a pop on a full FIFO overwrites the slot being read;
  // the popped word is sampled before the edge, so ordering is preserved.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_wdata;
    end
  end

  // Serializer next-state, bit timing and next tx level
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_sel_d = byte_sel_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = '0;
    bit_end    = (baud_cnt_q == BAUD_LAST);

    if (state_q != IDLE && !bit_end) begin
      baud_cnt_d = baud_cnt_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          word_d     = fifo_mem[rd_ptr];
          byte_sel_d = 1'b0;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cur_byte = byte_sel_d ? word_d[15:8] : word_d[7:0];

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      tx         <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      tx         <= tx_d;
    end
  end

  // Status flags, registered from next-state values so they track count/state exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (count_d != '0) || (state_d != IDLE);
      full <= (count_d == COUNT_FULL);
      if (clear_req) begin
        overflow <= 1'b0;
      end else if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign rdata = (mem_read && (mem_addr == STATUS_ADDR)) ?
                 {13'b0, overflow, full, busy} : 16'h0000;

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: 16-bit word entries; power of two, 2..16.
REQ-003 SHALL have input clk, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have input mem_write, 1 bit: the MEM-stage store strobe, valid for one cycle per store.
REQ-006 SHALL have input mem_read, 1 bit: the MEM-stage load strobe.
REQ-007 SHALL have input mem_addr, 16 bits: the MEM-stage word address (ALU result).
REQ-008 SHALL have input mem_wdata, 16 bits: the MEM-stage store data.
REQ-009 SHALL have output rdata, 16 bits: status read data.
REQ-010 SHALL have output tx, 1 bit: UART serial line, idle high.
REQ-011 SHALL have output busy, 1 bit: FIFO non-empty or serializer not IDLE.
REQ-012 SHALL have output full, 1 bit: FIFO count equals FIFO_DEPTH.
REQ-013 SHALL have output overflow, 1 bit: sticky dropped-write flag.

Function
REQ-014 Data register 0xFFFC: mem_write=1 with mem_addr=0xFFFC SHALL push mem_wdata into the FIFO at that clock edge.
REQ-015 Status register 0xFFFD: rdata SHALL be combinational {13'b0, overflow, full, busy} when mem_read=1 and mem_addr=0xFFFD, and 16'h0000 otherwise.
REQ-016 A write to 0xFFFD with mem_wdata[0]=1 SHALL clear overflow at that edge; mem_wdata[0]=0 SHALL have no effect.
REQ-017 Writes and reads to any other address SHALL be ignored.
REQ-018 A push when full=1 and no pop at the same edge SHALL be dropped, FIFO unchanged, and SHALL set overflow.
REQ-019 A simultaneous push and pop when full SHALL be accepted; the count SHALL stay at FIFO_DEPTH.
REQ-020 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strictly FIFO.
REQ-021 Serializer FSM states SHALL be IDLE, START, DATA, STOP.
REQ-022 IDLE with FIFO non-empty: at the next edge, pop the head word, set byte select to LOW, go to START.
REQ-023 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-024 DATA SHALL drive 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
REQ-025 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-026 At the end of STOP with byte select LOW: set byte select to HIGH and return to START without an idle cycle.
REQ-027 At the end of STOP with byte select HIGH: return to IDLE.
REQ-028 Each word SHALL be sent as two frames, low byte (mem_wdata[7:0]) first, then high byte.
REQ-029 Latency: a push to an empty FIFO while in IDLE at edge N SHALL give tx=0 after edge N+1.
REQ-030 One frame SHALL be exactly 10*CLKS_PER_BIT cycles; one word SHALL be exactly 20*CLKS_PER_BIT cycles.
REQ-031 Back-to-back words SHALL be separated by exactly one IDLE cycle (tx=1).
REQ-032 tx SHALL be registered, with no combinational path from any input.
REQ-033 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0.

Reset
REQ-034 Asserting reset at any time, including mid-frame, SHALL immediately force: tx=1, FSM IDLE, FIFO empty, busy=0, full=0, overflow=0, all counters 0.
REQ-035 After reset deasserts, the first transmission SHALL start no earlier than the edge following the first accepted push.

Verification
REQ-036 CLKS_PER_BIT=4; write 0x12A5 to 0xFFFC → frame 1: start 0, bits 1,0,1,0,0,1,0,1, stop 1; frame 2: 0x12 LSB first; tx idle high after exactly 80 cycles.
REQ-037 FIFO_DEPTH=4; 6 writes in consecutive cycles while the serializer is busy → first 5 accepted (first one popped immediately), 6th dropped; overflow=1; status read returns 0x0007; later write of 0x0001 to 0xFFFD → status 0x0003.
REQ-038 Push on the same edge as a pop with full=1 → accepted, no overflow, all 5 words later transmitted in order.
REQ-039 Assert reset mid-DATA of the low byte → tx=1 immediately, busy=0; new write 0x00FF transmits correctly from the start bit.
REQ-040 Writes to 0xFFFB and 0x0004 and reads of 0xFFFC → no FIFO change, rdata=0x0000, tx stays 1.
REQ-041 Two words back-to-back → exactly one cycle of tx=1 between the high-byte stop bit and the next start bit.
